// File: rtl/wb_collect.sv
// Writeback collector. Claims up to wwd prefix-valid FU result lanes per cycle, round-robin over FUs, into a registered writeback stage.
// Define WB_STATS_EN to build the saturating per-FU claim counters and the full-cycle counter; otherwise both stat outputs are tied to 0.
package wb_collect_pkg;
    typedef struct packed {
        logic [15:0] opid;  // bit 15 marks a valid result
        logic [31:0] data;
    } exe_bundle_t;
endpackage

module wb_collect
    import wb_collect_pkg::*;
#(
    parameter int nfu = 2,
    parameter int ewd = 4,
    parameter int wwd = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         hold,
    input  exe_bundle_t [nfu-1:0][ewd-1:0] resp,
    output logic [nfu-1:0][ewd-1:0]      claim,
    output exe_bundle_t [wwd-1:0]        wb,
    output logic [$clog2(wwd):0]         wb_num,
    output logic [nfu-1:0][31:0]         stat_claims,
    output logic [31:0]                  stat_full
);
    localparam int PW = (nfu > 1) ? $clog2(nfu) : 1;
    localparam int CW = $clog2(wwd) + 1;
    localparam logic [PW:0]   NFU_W = (PW + 1)'(nfu);
    localparam logic [CW-1:0] WWD_W = CW'(wwd);

    logic [PW-1:0]         rr_ptr;
    exe_bundle_t [wwd-1:0] nxt_wb;
    logic [CW-1:0]         used;
    logic                  left_over;

    // Walk FUs from rr_ptr; each FU contributes its valid prefix until the slots run out.
    always_comb begin
        logic [PW:0]   fsum;
        logic [PW-1:0] f;
        logic          alive;
        // NOTE: every variable written here gets a default first so no latch is inferred.
        claim     = '0;
        nxt_wb    = '0;
        used      = '0;
        left_over = 1'b0;
        fsum      = '0;
        f         = '0;
        alive     = 1'b0;
        if (!rst && !flush && !hold) begin
            for (int k = 0; k < nfu; k++) begin
                fsum = {1'b0, rr_ptr} + (PW + 1)'(k);
                if (fsum >= NFU_W) fsum = fsum - NFU_W;
                f     = fsum[PW-1:0];
                alive = 1'b1;
                for (int i = 0; i < ewd; i++) begin
                    alive = alive & resp[f][i].opid[15];
                    if (alive) begin
                        if (used < WWD_W) begin
                            claim[f][i] = 1'b1;
                            for (int s = 0; s < wwd; s++) begin
                                if (used == CW'(s)) nxt_wb[s] = resp[f][i];
                            end
                            used = used + CW'(1);
                        end else begin
                            left_over = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wb     <= '0;
            wb_num <= '0;
            rr_ptr <= '0;
        end else if (!hold) begin
            wb     <= nxt_wb;
            wb_num <= used;
            if (|claim) rr_ptr <= (rr_ptr == PW'(nfu - 1)) ? '0 : rr_ptr + PW'(1);
        end
    end

`ifdef WB_STATS_EN
    logic [nfu-1:0][31:0] fu_cnt;

    always_comb begin
        fu_cnt = '0;
        for (int f = 0; f < nfu; f++) begin
            for (int i = 0; i < ewd; i++) begin
                fu_cnt[f] = fu_cnt[f] + 32'(claim[f][i]);
            end
        end
    end

    // Counters survive flush; claim and left_over are already zero when stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_claims <= '0;
            stat_full   <= '0;
        end else begin
            for (int f = 0; f < nfu; f++) begin
                stat_claims[f] <= (fu_cnt[f] > ~stat_claims[f]) ? '1 : stat_claims[f] + fu_cnt[f];
            end
            if (left_over && stat_full != '1) stat_full <= stat_full + 32'd1;
        end
    end
`else
    assign stat_claims = '0;
    assign stat_full   = '0;
`endif

endmodule

// File: doc/wb_collect.md
Name: wb_collect

Overview:
- Writeback collector directly downstream of the integer execution unit and its sibling functional units (multiply/divide, load/store).
- Each cycle it claims up to `wwd` finished results from the FUs' execution output queues, which are presented as ordered lane bundles.
- Claimed results pass through a registered writeback stage that feeds the physical register file write ports and the reorder buffer completion ports.
- FU arbitration is round-robin for fairness. The stage supports flush and downstream hold.

Parameters:
- nfu, 2, number of functional units feeding the collector; FU 0 is the ALU.
- ewd, 4, result lanes presented per FU.
- wwd, 4, writeback slots per cycle; 1 <= wwd <= nfu*ewd.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- flush  input  1  pipeline flush, synchronous.
- hold  input  1  downstream not accepting; freeze the writeback register.
- resp  input  exe_bundle_t [nfu-1:0][ewd-1:0]  FU results. A lane is valid when opid[15] is 1.
- claim  output  logic [nfu-1:0][ewd-1:0]  combinational; claim[f][i] consumes lane i of FU f this cycle.
- wb  output  exe_bundle_t [wwd-1:0]  registered writeback bundles. A slot is valid when opid[15] is 1.
- wb_num  output  $clog2(wwd)+1 bits  count of valid wb slots.
- stat_claims  output  [nfu-1:0][31:0]  per-FU claim counters (see Optional Feature).
- stat_full  output  32  cycles in which valid lanes were left unclaimed.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: wb all zero, wb_num 0, rr_ptr 0, stat counters 0. claim is forced to 0 while rst is high.
- Lane validity per FU:
  - Only the valid prefix counts: lanes 0..k-1 where all are valid and lane k is invalid or k = ewd.
  - Valid lanes after the first invalid lane are ignored and never claimed.
- Claim selection (combinational, when rst=0, flush=0, hold=0):
  - Visit FUs in order rr_ptr, rr_ptr+1, ... modulo nfu.
  - Within each FU, visit its prefix lanes in order. Assign each visited lane to the next free slot until all wwd slots are used.
  - Claims per FU therefore always form a prefix. A partially claimed FU keeps its remaining lanes for later cycles.
- Gating: when flush or hold is 1, claim is all 0.
- Writeback register, on posedge clk:
  - rst or flush: wb <= 0, wb_num <= 0.
  - hold: wb and wb_num retain their values.
  - Otherwise: wb[s] <= the lane assigned to slot s, or 0 if slot s is unused; wb_num <= number of assigned slots.
- Writeback latency: a result claimed in cycle t appears on wb in cycle t+1.
- Slot packing: filled slots are packed from slot 0 with no gaps. Slot order equals visit order.
- Round-robin pointer: in a cycle with at least one claim, rr_ptr <= (rr_ptr+1) mod nfu. Otherwise rr_ptr is unchanged. A flush resets it to 0.
- Boundary cases:
  - All lanes invalid: no claims, wb cleared next cycle.
  - Total valid count equal to wwd: everything is claimed.
  - Total valid count greater than wwd: excess lanes are not claimed, and stat_full increments.
  - A wrapping pointer stays within 0..nfu-1.
- Simultaneous rst and flush: reset wins. Reset or flush has priority over hold.

Optional Feature:
- Macro: WB_STATS_EN.
- Defined: stat_claims[f] increments by the claim count of FU f in each unstalled cycle. stat_full increments in each cycle with rst=0, flush=0, hold=0 where some prefix-valid lane was left unclaimed. Both saturate at 2^32-1 and are cleared by rst only.
- Undefined: counter logic is omitted and both outputs are tied to 0.

Test Plan:
- Reset, then ALU presents 2 valid lanes (opid 0x8001, 0x8002) and FU1 presents none -> claim[0]=4'b0011, claim[1]=0. Next cycle wb[0].opid=0x8001, wb[1].opid=0x8002, wb_num=2, rr_ptr=1.
- Both FUs present 4 valid lanes each with wwd=4, rr_ptr=0 -> cycle 1 claims FU0 lanes 0-3 only, stat_full=1. Cycle 2 claims FU1 lanes 0-3, and the refilled FU0 is unclaimed.
- FU0 lanes valid/invalid/valid/valid -> only lane 0 claimed. wb_num=1 next cycle.
- hold=1 for 3 cycles with valid lanes on inputs -> claim=0 and wb unchanged throughout. After hold drops, claiming resumes at the held rr_ptr.
- flush asserted while wb holds 3 valid results and hold=1 -> claim=0, and the next cycle wb is all zero, wb_num=0, rr_ptr=0.
- With WB_STATS_EN defined, 10 cycles of FU1 presenting 1 valid lane while FU0 is idle -> stat_claims[1]=10, stat_claims[0]=0, stat_full=0. With it undefined, all stat outputs are 0.
